fir_overflow_probe: RTL and testbench

Synthesisable, parametrised stimulus generator and overflow monitor for FIR filter characterisation. Drives worst-case full-scale input patterns into the filter under test and watches the filter output for magnitude violations. Sits beside `fir_filter`: its `data_out` feeds the filter input and the filter output returns on `fir_out`. It reports a sticky overflow flag, the index of the first violation, a violation count and the peak output.

---
 rtl/fir_overflow_probe.sv | 195 +++++++++++++++++++
 tb/tb_fir_overflow_probe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_overflow_probe.sv
// Purpose : stimulus generator and overflow monitor for FIR characterisation.
//           Drives full-scale patterns on data_out and checks |fir_out|
//           against a threshold inside a window delayed by FIR_LATENCY.
// Latency : sample k on data_out in cycle T+1+k after start edge T; done in
//           cycle T+run_len+FIR_LATENCY+1.
// Backpressure: none; start is only honoured in IDLE, abort in RUN/DRAIN.
// Ports   : clk, rst (async, active high); start/abort/mode/run_len/threshold
//           control; fir_out monitored input; data_out/sample_valid stimulus;
//           busy/done status; overflow_flag/first_ovf_idx/ovf_count/peak_out.
module fir_overflow_probe #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int FIR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [CNT_WIDTH-1:0]  run_len,
  input  logic [OUT_WIDTH-1:0]  threshold,
  input  logic [OUT_WIDTH-1:0]  fir_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_flag,
  output logic [CNT_WIDTH-1:0]  first_ovf_idx,
  output logic [CNT_WIDTH-1:0]  ovf_count,
  output logic [OUT_WIDTH-1:0]  peak_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // DRAIN counts down from FIR_LATENCY-1 to 0, i.e. FIR_LATENCY cycles.
  localparam logic [3:0] DRAIN_LAST = (FIR_LATENCY > 0) ? 4'(FIR_LATENCY - 1) : 4'd0;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                    input logic [CNT_WIDTH-1:0] k);
    case (m)
      2'd0:    pattern = MAX_V;
      2'd1:    pattern = MIN_V;
      2'd2:    pattern = k[0] ? MIN_V : MAX_V;
      default: pattern = (k == '0) ? MAX_V : '0;
    endcase
  endfunction

  logic [1:0]            state_q, state_d;
  logic [1:0]            mode_q;
  logic [CNT_WIDTH-1:0]  run_len_q;
  logic [OUT_WIDTH-1:0]  thr_q;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [3:0]            drain_q, drain_d;
  logic [CNT_WIDTH-1:0]  mon_idx_q;
  logic                  flag_q;
  logic [CNT_WIDTH-1:0]  first_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [OUT_WIDTH-1:0]  peak_q;
  logic                  mon_valid;

  logic start_ok, abort_ok, last_sample;
  assign start_ok    = (state_q == S_IDLE) && start;
  assign abort_ok    = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign last_sample = (idx_q == run_len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = '0;
    valid_d = 1'b0;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (run_len != '0) begin
            state_d = S_RUN;
            idx_d   = '0;
            data_d  = pattern(mode, '0);
            valid_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_sample) begin
          state_d = (FIR_LATENCY == 0) ? S_DONE : S_DRAIN;
          drain_d = DRAIN_LAST;
        end else begin
          idx_d   = idx_q + 1'b1;
          data_d  = pattern(mode_q, idx_q + 1'b1);
          valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort)                state_d = S_IDLE;
        else if (drain_q == 4'd0) state_d = S_DONE;
        else                      drain_d = drain_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      run_len_q <= '0;
      thr_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drain_q <= drain_d;
      if (start_ok) begin
        mode_q    <= mode;
        run_len_q <= run_len;
        thr_q     <= threshold;
      end
    end
  end

  // Monitor window: sample_valid delayed to line up with the filter output.
  generate
    if (FIR_LATENCY == 0) begin : g_nodly
      assign mon_valid = valid_q;
    end else begin : g_dly
      logic [FIR_LATENCY-1:0] sr_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           sr_q <= '0;
        else if (abort_ok) sr_q <= '0;
        else               sr_q <= (sr_q << 1) | FIR_LATENCY'(valid_q);
      end
      assign mon_valid = sr_q[FIR_LATENCY-1];
    end
  endgenerate

  // One extra bit so the most-negative value has an exact, non-wrapping magnitude.
  logic [OUT_WIDTH:0] fir_ext, fir_mag, peak_ext, peak_mag, thr_ext;
  assign fir_ext  = {fir_out[OUT_WIDTH-1], fir_out};
  assign fir_mag  = fir_out[OUT_WIDTH-1] ? (~fir_ext + 1'b1) : fir_ext;
  assign peak_ext = {peak_q[OUT_WIDTH-1], peak_q};
  assign peak_mag = peak_q[OUT_WIDTH-1] ? (~peak_ext + 1'b1) : peak_ext;
  assign thr_ext  = {1'b0, thr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_idx_q <= '0;
      flag_q    <= 1'b0;
      first_q   <= '0;
      cnt_q     <= '0;
      peak_q    <= '0;
    end else if (start_ok) begin
      mon_idx_q <= '0;
      flag_q    <= 1'b0;
      first_q   <= '0;
      cnt_q     <= '0;
      peak_q    <= '0;
    end else if (mon_valid && !abort_ok) begin
      // An abort freezes results exactly as they stood before that edge.
      mon_idx_q <= mon_idx_q + 1'b1;
      if (fir_mag > thr_ext) begin
        flag_q <= 1'b1;
        if (!flag_q)    first_q <= mon_idx_q;
        if (cnt_q != '1) cnt_q  <= cnt_q + 1'b1;
      end
      if (fir_mag > peak_mag) peak_q <= fir_out;
    end
  end

  assign data_out      = data_q;
  assign sample_valid  = valid_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign overflow_flag = flag_q;
  assign first_ovf_idx = first_q;
  assign ovf_count     = cnt_q;
  assign peak_out      = peak_q;

endmodule

// File: tb/tb_fir_overflow_probe.sv
module tb_fir_overflow_probe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] run_len = '0, threshold = '0;
  logic [31:0] fir_out;
  logic [15:0] data_out;
  logic        sample_valid, busy, done, overflow_flag;
  logic [31:0] first_ovf_idx, ovf_count, peak_out;

  // Saturation instance: 3-bit counters, zero filter latency.
  logic        start_s = 1'b0;
  logic [2:0]  run_len_s = '0;
  logic [31:0] fir_out_s = 32'h7FFF_FFFF;
  logic [15:0] data_out_s;
  logic        sample_valid_s, busy_s, done_s, overflow_flag_s;
  logic [2:0]  first_ovf_idx_s, ovf_count_s;
  logic [31:0] peak_out_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_overflow_probe #(.DATA_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(32), .FIR_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .run_len(run_len), .threshold(threshold), .fir_out(fir_out),
    .data_out(data_out), .sample_valid(sample_valid), .busy(busy), .done(done),
    .overflow_flag(overflow_flag), .first_ovf_idx(first_ovf_idx),
    .ovf_count(ovf_count), .peak_out(peak_out));

  fir_overflow_probe #(.DATA_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(3), .FIR_LATENCY(0)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(1'b0), .mode(2'd0),
    .run_len(run_len_s), .threshold(32'd0), .fir_out(fir_out_s),
    .data_out(data_out_s), .sample_valid(sample_valid_s), .busy(busy_s), .done(done_s),
    .overflow_flag(overflow_flag_s), .first_ovf_idx(first_ovf_idx_s),
    .ovf_count(ovf_count_s), .peak_out(peak_out_s));

  // Filter model: two-cycle delay line, then scale / pass / forced constant.
  logic [15:0] h0 = '0, h1 = '0;
  logic [1:0]  fsel = 2'd0;
  logic [31:0] fir_force = '0;
  logic signed [31:0] hx;
  always @(posedge clk) begin
    h0 <= data_out;
    h1 <= h0;
  end
  assign hx = {{16{h1[15]}}, h1};
  assign fir_out = (fsel == 2'd0) ? (hx <<< 2) : (fsel == 2'd1) ? hx : fir_force;

  typedef struct {
    logic        flag;
    logic [31:0] idx;
    logic [31:0] cnt;
    logic [31:0] peak;
  } res_t;

  logic [15:0] samp_q[$];
  res_t        res_q[$];

  function automatic logic [15:0] exp_sample(input logic [1:0] m, input int k);
    case (m)
      2'd0:    return 16'h7FFF;
      2'd1:    return 16'h8000;
      2'd2:    return (k % 2 == 1) ? 16'h8000 : 16'h7FFF;
      default: return (k == 0) ? 16'h7FFF : 16'h0000;
    endcase
  endfunction

  // Pushes expected samples and final results, runs one start..done sequence,
  // and returns at the falling edge of the done cycle.
  task automatic run_probe(input logic [1:0] m, input int len, input logic [31:0] thr,
                           input logic [1:0] fs, input logic [31:0] fv, input bit poke,
                           output int done_c, output int vcnt);
    res_t   r;
    longint y, mag, pkm, xs;
    logic [15:0] x, got;
    r.flag = 1'b0; r.idx = '0; r.cnt = '0; r.peak = '0;
    pkm = 0;
    for (int k = 0; k < len; k++) begin
      x = exp_sample(m, k);
      samp_q.push_back(x);
      xs = longint'($signed(x));
      y = (fs == 2'd0) ? xs * 4 : (fs == 2'd1) ? xs : longint'($signed(fv));
      mag = (y < 0) ? -y : y;
      if (mag > longint'({32'b0, thr})) begin
        if (!r.flag) r.idx = k;
        r.flag = 1'b1;
        r.cnt  = r.cnt + 1;
      end
      if (mag > pkm) begin
        pkm = mag;
        r.peak = y[31:0];
      end
    end
    res_q.push_back(r);

    @(negedge clk);
    fsel = fs; fir_force = fv; mode = m; run_len = len; threshold = thr; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    done_c = -1; vcnt = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (poke && c == 2) begin start = 1'b1; run_len = 20; end
      else if (poke && c == 3) start = 1'b0;
      if (sample_valid) begin
        vcnt++;
        checks++;
        if (samp_q.size() == 0) begin
          failures++; $display("FAIL extra_sample cycle=%0d got=%h", c, data_out);
        end else begin
          got = samp_q.pop_front();
          if (data_out !== got) begin
            failures++; $display("FAIL sample cycle=%0d got=%h exp=%h", c, data_out, got);
          end
        end
      end else begin
        checks++;
        if (data_out !== 16'h0) begin
          failures++; $display("FAIL idle_data cycle=%0d got=%h exp=0", c, data_out);
        end
      end
      checks++;
      if (done) begin
        if (busy !== 1'b0) begin
          failures++; $display("FAIL busy_in_done got=%b exp=0", busy);
        end
        done_c = c;
        break;
      end else if (busy !== 1'b1) begin
        failures++; $display("FAIL busy_in_run cycle=%0d got=%b exp=1", c, busy);
      end
    end
    start = 1'b0;
    checks++;
    if (done_c < 0) begin
      failures++; $display("FAIL done_timeout got=none exp=done");
    end
    r = res_q.pop_front();
    checks++;
    if ({overflow_flag, first_ovf_idx, ovf_count, peak_out} !== {r.flag, r.idx, r.cnt, r.peak}) begin
      failures++;
      $display("FAIL results got flag=%b idx=%0d cnt=%0d peak=%h exp flag=%b idx=%0d cnt=%0d peak=%h",
               overflow_flag, first_ovf_idx, ovf_count, peak_out, r.flag, r.idx, r.cnt, r.peak);
    end
    checks++;
    if (samp_q.size() != 0) begin
      failures++; $display("FAIL missing_samples got=%0d exp=0", samp_q.size());
    end
    samp_q.delete();
  endtask

  task automatic expect_int(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sample_valid, data_out, overflow_flag, first_ovf_idx, ovf_count, peak_out} !== '0) begin
      failures++; $display("FAIL reset_main got=%h exp=0",
        {busy, done, sample_valid, data_out, overflow_flag, first_ovf_idx, ovf_count, peak_out});
    end
    checks++;
    if ({busy_s, done_s, sample_valid_s, data_out_s, overflow_flag_s, first_ovf_idx_s, ovf_count_s, peak_out_s} !== '0) begin
      failures++; $display("FAIL reset_sat got=%h exp=0",
        {busy_s, done_s, sample_valid_s, data_out_s, overflow_flag_s, first_ovf_idx_s, ovf_count_s, peak_out_s});
    end
    rst = 1'b0;
  endtask

  task automatic test_mode0();
    int dc, vc;
    run_probe(2'd0, 8, 32'h0001_FFFF, 2'd0, '0, 1'b0, dc, vc);
    expect_int("mode0_done_cycle", dc, 11);
    expect_int("mode0_valid_cycles", vc, 8);
    expect_int("mode0_flag", overflow_flag, 0);
    expect_int("mode0_peak", peak_out, 131068);
  endtask

  task automatic test_mode2();
    int dc, vc;
    run_probe(2'd2, 8, 32'd32767, 2'd1, '0, 1'b0, dc, vc);
    expect_int("mode2_flag", overflow_flag, 1);
    expect_int("mode2_first", first_ovf_idx, 1);
    expect_int("mode2_count", ovf_count, 4);
    expect_int("mode2_peak", peak_out, 32'hFFFF_8000);
  endtask

  task automatic test_most_neg();
    int dc, vc;
    run_probe(2'd0, 3, 32'h7FFF_FFFF, 2'd2, 32'h8000_0000, 1'b0, dc, vc);
    expect_int("mneg_count", ovf_count, 3);
    expect_int("mneg_peak", peak_out, 32'h8000_0000);
    expect_int("mneg_first", first_ovf_idx, 0);
    run_probe(2'd0, 3, 32'h8000_0000, 2'd2, 32'h8000_0000, 1'b0, dc, vc);
    expect_int("mneg_thr_flag", overflow_flag, 0);
  endtask

  task automatic test_impulse();
    int dc, vc;
    run_probe(2'd3, 4, 32'hFFFF_FFFF, 2'd1, '0, 1'b0, dc, vc);
    expect_int("impulse_valid_cycles", vc, 4);
    expect_int("impulse_done_cycle", dc, 7);
  endtask

  task automatic test_abort();
    bit saw_done;
    @(negedge clk);
    fsel = 2'd1; mode = 2'd2; run_len = 10; threshold = 32'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({sample_valid, data_out} !== {1'b1, 16'h8000}) begin
      failures++; $display("FAIL abort_sample3 got=%b/%h exp=1/8000", sample_valid, data_out);
    end
    expect_int("abort_count_before", ovf_count, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, sample_valid, data_out} !== '0) begin
      failures++; $display("FAIL abort_stop got=%b/%b/%h exp=0/0/0000", busy, sample_valid, data_out);
    end
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    expect_int("abort_no_done", saw_done, 0);
    expect_int("abort_count_held", ovf_count, 1);
  endtask

  task automatic test_reset_mid_drain();
    int dc, vc;
    @(negedge clk);
    fsel = 2'd0; mode = 2'd0; run_len = 4; threshold = 32'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, sample_valid} !== 2'b10) begin
      failures++; $display("FAIL drain_state got=%b%b exp=10", busy, sample_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sample_valid, data_out, overflow_flag, first_ovf_idx, ovf_count, peak_out} !== '0) begin
      failures++; $display("FAIL reset_mid_drain got=%h exp=0",
        {busy, done, sample_valid, data_out, overflow_flag, first_ovf_idx, ovf_count, peak_out});
    end
    @(negedge clk); rst = 1'b0;
    run_probe(2'd0, 4, 32'h0001_FFFF, 2'd0, '0, 1'b0, dc, vc);
    expect_int("after_reset_done_cycle", dc, 7);
  endtask

  task automatic test_zero_len();
    int dc, vc;
    run_probe(2'd0, 0, 32'd0, 2'd1, '0, 1'b0, dc, vc);
    expect_int("zero_len_done_cycle", dc, 1);
    expect_int("zero_len_valid", vc, 0);
  endtask

  task automatic test_busy_start();
    int dc, vc;
    run_probe(2'd1, 5, 32'hFFFF_FFFF, 2'd1, '0, 1'b1, dc, vc);
    expect_int("busy_start_done_cycle", dc, 8);
    expect_int("busy_start_valid", vc, 5);
  endtask

  task automatic test_back_to_back();
    int dc, vc;
    run_probe(2'd0, 2, 32'h0001_FFFF, 2'd0, '0, 1'b0, dc, vc);
    run_len = 3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, sample_valid} !== 2'b00) begin
      failures++; $display("FAIL start_in_done got=%b%b exp=00", busy, sample_valid);
    end
    run_probe(2'd2, 3, 32'd32767, 2'd1, '0, 1'b0, dc, vc);
    expect_int("b2b_done_cycle", dc, 6);
  endtask

  task automatic test_saturation();
    int dc;
    @(negedge clk);
    run_len_s = 3'd7; start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    dc = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done_s) begin dc = c; break; end
    end
    expect_int("sat_done_cycle", dc, 8);
    expect_int("sat_count", ovf_count_s, 7);
    expect_int("sat_flag", overflow_flag_s, 1);
    expect_int("sat_first", first_ovf_idx_s, 0);
    expect_int("sat_peak", peak_out_s, 32'h7FFF_FFFF);
    repeat (3) @(negedge clk);
    expect_int("sat_count_held", ovf_count_s, 7);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode2();
    test_most_neg();
    test_impulse();
    test_abort();
    test_reset_mid_drain();
    test_zero_len();
    test_busy_start();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
